pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 4, SHALL set the EX-stage occupancy of a multi-cycle multiply (legal range 2..15).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 IF_ID_rn1, IF_ID_rn2  input  4 each  SHALL carry the source register numbers of the instruction in ID.
REQ-005 ID_EX_wn  input  4  SHALL carry the destination register of the instruction in EX.
REQ-006 ID_EX_MemRead  input  1  SHALL mark the instruction in EX as a load.
REQ-007 ID_EX_mul  input  1  SHALL mark the instruction in EX as a multi-cycle multiply.
REQ-008 branch_taken  input  1  SHALL mark a taken branch resolved in EX.
REQ-009 EX_MEM_mem_req, mem_ready  input  1 each  SHALL be the MEM-stage access request and data-memory ready.
REQ-010 halt  input  1  SHALL mark a HALT instruction in EX.
REQ-011 pc_write, IF_ID_write  output  1 each  SHALL enable the PC and IF/ID register updates.
REQ-012 IF_ID_flush, ID_EX_bubble  output  1 each  SHALL zero IF/ID and insert a NOP into ID/EX respectively.
REQ-013 ID_EX_write, EX_MEM_write, MEM_WB_write  output  1 each  SHALL enable the respective pipeline register updates.
REQ-014 mul_done  output  1  SHALL pulse one cycle when the multiply result is valid in EX.
REQ-015 state  output  3  SHALL expose the FSM state; stall_cnt  output  16  SHALL count stalled cycles.

Function
REQ-016 FSM states SHALL be RUN=0, MUL_WAIT=1, MEM_WAIT=2, HALTED=3.
REQ-017 In RUN with no event, all *_write SHALL be 1 and IF_ID_flush, ID_EX_bubble, mul_done 0.
REQ-018 Load-use SHALL be ID_EX_MemRead && ID_EX_wn!=0 && (ID_EX_wn==IF_ID_rn1 || ID_EX_wn==IF_ID_rn2); in RUN it SHALL, same cycle, drive pc_write=0, IF_ID_write=0, ID_EX_bubble=1, state stays RUN.
REQ-019 branch_taken in RUN SHALL, same cycle, drive IF_ID_flush=1 and ID_EX_bubble=1 with pc_write=1; state stays RUN.
REQ-020 ID_EX_mul in RUN SHALL load the counter with MUL_CYCLES-2 and enter MUL_WAIT; that cycle pc_write, IF_ID_write, ID_EX_write = 0 and EX_MEM_write = 0.
REQ-021 In MUL_WAIT, pc_write, IF_ID_write, ID_EX_write, EX_MEM_write SHALL be 0 and the counter SHALL decrement; at counter==0, mul_done=1, EX_MEM_write=1, ID_EX_bubble=1, next state RUN. Total EX occupancy = MUL_CYCLES cycles.
REQ-022 EX_MEM_mem_req && !mem_ready in RUN or MUL_WAIT SHALL freeze every stage (all *_write=0, no bubble/flush) and enter MEM_WAIT, saving the return state; MUL_WAIT's counter SHALL not decrement while frozen.
REQ-023 In MEM_WAIT all *_write SHALL stay 0 until mem_ready=1; that cycle all writes follow the saved state's rules and the FSM returns to it.
REQ-024 halt in RUN SHALL enter HALTED next cycle; in HALTED pc_write, IF_ID_write, ID_EX_write SHALL be 0, EX_MEM_write, MEM_WB_write 1 for draining; exit only by rst.
REQ-025 Simultaneous-event priority SHALL be: memory wait > halt > branch_taken > mul > load-use; a branch concurrent with load-use SHALL flush, not stall.
REQ-026 stall_cnt SHALL increment every cycle pc_write=0 outside HALTED and saturate at 16'hFFFF.

Reset
REQ-027 rst SHALL, on the clock edge, force state=RUN, counter=0, saved state=RUN, stall_cnt=0, mul_done=0; outputs then obey REQ-017.
REQ-028 rst SHALL override any state, including mid-MUL_WAIT and mid-MEM_WAIT; no pending multiply survives.

Structure
REQ-029 State encodings and the default MUL_CYCLES SHALL live in the shared processor package with the register-number width (4).
REQ-030 The load-use comparator SHALL be a sub-module named hazard_detect; the FSM, counter and stall counter stay in pipeline_ctrl.

Verification
REQ-031 ID_EX_MemRead=1, ID_EX_wn=5, IF_ID_rn2=5 -> one cycle pc_write=0, IF_ID_write=0, ID_EX_bubble=1, stall_cnt 0->1; ID_EX_wn=0 -> no stall.
REQ-032 branch_taken=1 with load-use true -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1, stall_cnt unchanged.
REQ-033 ID_EX_mul=1, MUL_CYCLES=4 -> EX_MEM_write=0 for 3 cycles, mul_done=1 on 4th, then RUN.
REQ-034 Multiply with mem_ready low 2 cycles in its 2nd cycle -> state 1,2,2,1,...; mul_done delayed exactly 2 cycles.
REQ-035 halt=1 -> state=3, pc_write=0 held 20 cycles; rst=1 -> state=0, stall_cnt=0 next edge.
REQ-036 Force 70000 stall cycles -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared processor package for the five-stage pipeline.
// Contents:
//   REG_W              register-number width
//   MUL_CYCLES_DEFAULT default EX-stage occupancy of a multi-cycle multiply
//   MUL_CNT_W          width of the multiply occupancy counter
//   STALL_W            width of the stalled-cycle counter
//   ctrlState_t        pipeline controller FSM states
//   ctrlOut_t          bundle of the controller's per-cycle stage controls
// ---------------------------------------------------------------------------
package pipeline_pkg;

   localparam int REG_W              = 4;
   localparam int MUL_CYCLES_DEFAULT = 4;
   localparam int MUL_CNT_W          = 4;
   localparam int STALL_W            = 16;

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      MUL_WAIT = 3'd1,
      MEM_WAIT = 3'd2,
      HALTED   = 3'd3
   } ctrlState_t;

   typedef struct packed {
      logic pcWrite;
      logic ifIdWrite;
      logic idExWrite;
      logic exMemWrite;
      logic memWbWrite;
      logic ifIdFlush;
      logic idExBubble;
      logic mulDone;
   } ctrlOut_t;

   // Every register advances and nothing is squashed: the free-running case.
   function automatic ctrlOut_t runControls();
      ctrlOut_t c;
      c            = '0;
      c.pcWrite    = 1'b1;
      c.ifIdWrite  = 1'b1;
      c.idExWrite  = 1'b1;
      c.exMemWrite = 1'b1;
      c.memWbWrite = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Load-use comparator: flags when the load currently in EX writes a register
// that the instruction in ID wants to read. Register 0 is hard-wired zero, so
// a load targeting it never creates a dependency.
// Ports:
//   exMemRead  in   instruction in EX is a load
//   exWn       in   destination register of the instruction in EX
//   idRn1/2    in   source registers of the instruction in ID
//   loadUse    out  load-use hazard present this cycle
// ---------------------------------------------------------------------------
module hazard_detect
   import pipeline_pkg::*;
(
   input  logic             exMemRead,
   input  logic [REG_W-1:0] exWn,
   input  logic [REG_W-1:0] idRn1,
   input  logic [REG_W-1:0] idRn2,
   output logic             loadUse
);

   // Purely combinational so the stall can be raised in the same cycle.
   assign loadUse = exMemRead && (exWn != '0) && ((exWn == idRn1) || (exWn == idRn2));

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush controller for the five-stage pipeline. Handles
// load-use stalls, taken-branch flushes, multi-cycle multiplies, data-memory
// wait states and HALT draining, and counts cycles in which the PC stalls.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   IF_ID_rn1, IF_ID_rn2             source registers of the ID instruction
//   ID_EX_wn, ID_EX_MemRead          destination / load flag of EX instruction
//   ID_EX_mul                        EX instruction is a multi-cycle multiply
//   branch_taken                     taken branch resolved in EX
//   EX_MEM_mem_req, mem_ready        MEM-stage request and memory ready
//   halt                             HALT instruction in EX
//   pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write
//                                    register update enables
//   IF_ID_flush, ID_EX_bubble        squash IF/ID, insert NOP into ID/EX
//   mul_done                         multiply result valid in EX this cycle
//   state                            FSM state, stall_cnt saturating stalls
// ---------------------------------------------------------------------------
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [REG_W-1:0]   IF_ID_rn1,
   input  logic [REG_W-1:0]   IF_ID_rn2,
   input  logic [REG_W-1:0]   ID_EX_wn,
   input  logic               ID_EX_MemRead,
   input  logic               ID_EX_mul,
   input  logic               branch_taken,
   input  logic               EX_MEM_mem_req,
   input  logic               mem_ready,
   input  logic               halt,
   output logic               pc_write,
   output logic               IF_ID_write,
   output logic               IF_ID_flush,
   output logic               ID_EX_bubble,
   output logic               ID_EX_write,
   output logic               EX_MEM_write,
   output logic               MEM_WB_write,
   output logic               mul_done,
   output logic [2:0]         state,
   output logic [STALL_W-1:0] stall_cnt
);

   // The cycle that starts the multiply counts as one, and the final MUL_WAIT
   // cycle (counter at zero) counts as another.
   localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(MUL_CYCLES - 2);

   ctrlState_t             currentState, nextState;
   ctrlState_t             savedState, nextSaved;
   ctrlState_t             ruleState;
   logic [MUL_CNT_W-1:0]   mulCnt, nextMulCnt;
   logic [STALL_W-1:0]     stallCnt;
   logic                   loadUse;
   logic                   memBlock;
   ctrlOut_t               ctl;

   hazard_detect hazardDetect (
      .exMemRead (ID_EX_MemRead),
      .exWn      (ID_EX_wn),
      .idRn1     (IF_ID_rn1),
      .idRn2     (IF_ID_rn2),
      .loadUse   (loadUse)
   );

   // State, return state and multiply counter. Reset abandons any pending
   // multiply or memory wait outright.
   always_ff @(posedge clk) begin
      if (rst) begin
         currentState <= RUN;
         savedState   <= RUN;
         mulCnt       <= '0;
      end else begin
         currentState <= nextState;
         savedState   <= nextSaved;
         mulCnt       <= nextMulCnt;
      end
   end

   // Stalled-cycle counter. HALTED is a deliberate stop, not a stall, so it
   // is excluded; the count sticks at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stallCnt <= '0;
      end else if (!ctl.pcWrite && (currentState != HALTED) && (stallCnt != '1)) begin
         stallCnt <= stallCnt + 16'd1;
      end
   end

   // Next-state and control decode. When a memory wait ends, the cycle is
   // evaluated with the rules of the state that was interrupted (ruleState),
   // so a resumed multiply continues counting from where it froze.
   // Priority inside RUN: memory wait > halt > branch > multiply > load-use,
   // so a branch squashes the dependent instruction instead of stalling it.
   always_comb begin
      nextState  = currentState;
      nextSaved  = savedState;
      nextMulCnt = mulCnt;
      ctl        = runControls();
      memBlock   = EX_MEM_mem_req && !mem_ready;
      ruleState  = (currentState == MEM_WAIT) ? savedState : currentState;

      if (currentState == HALTED) begin
         ctl.pcWrite   = 1'b0;
         ctl.ifIdWrite = 1'b0;
         ctl.idExWrite = 1'b0;
      end else if ((currentState == MEM_WAIT) && !mem_ready) begin
         ctl = '0;
      end else if ((currentState != MEM_WAIT) && memBlock) begin
         ctl       = '0;
         nextState = MEM_WAIT;
         nextSaved = currentState;
      end else if (ruleState == MUL_WAIT) begin
         ctl.pcWrite   = 1'b0;
         ctl.ifIdWrite = 1'b0;
         ctl.idExWrite = 1'b0;
         if (mulCnt == '0) begin
            ctl.mulDone    = 1'b1;
            ctl.idExBubble = 1'b1;
            nextState      = RUN;
         end else begin
            ctl.exMemWrite = 1'b0;
            nextMulCnt     = mulCnt - 1'b1;
            nextState      = MUL_WAIT;
         end
      end else begin
         nextState = RUN;
         if (halt) begin
            nextState = HALTED;
         end else if (branch_taken) begin
            ctl.ifIdFlush  = 1'b1;
            ctl.idExBubble = 1'b1;
         end else if (ID_EX_mul) begin
            ctl.pcWrite    = 1'b0;
            ctl.ifIdWrite  = 1'b0;
            ctl.idExWrite  = 1'b0;
            ctl.exMemWrite = 1'b0;
            nextMulCnt     = MUL_LOAD;
            nextState      = MUL_WAIT;
         end else if (loadUse) begin
            ctl.pcWrite    = 1'b0;
            ctl.ifIdWrite  = 1'b0;
            ctl.idExBubble = 1'b1;
         end
      end
   end

   assign pc_write     = ctl.pcWrite;
   assign IF_ID_write  = ctl.ifIdWrite;
   assign ID_EX_write  = ctl.idExWrite;
   assign EX_MEM_write = ctl.exMemWrite;
   assign MEM_WB_write = ctl.memWbWrite;
   assign IF_ID_flush  = ctl.ifIdFlush;
   assign ID_EX_bubble = ctl.idExBubble;
   assign mul_done     = ctl.mulDone;
   assign state        = currentState;
   assign stall_cnt    = stallCnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl: a behavioural model of the
// controller checked every cycle, directed scenarios with literal
// expectations, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

   localparam int MC = 4;

   logic        clk;
   logic        rst;
   logic [3:0]  IF_ID_rn1, IF_ID_rn2, ID_EX_wn;
   logic        ID_EX_MemRead, ID_EX_mul, branch_taken;
   logic        EX_MEM_mem_req, mem_ready, halt;
   logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble;
   logic        ID_EX_write, EX_MEM_write, MEM_WB_write, mul_done;
   logic [2:0]  state;
   logic [15:0] stall_cnt;

   int testsRun = 0;
   int failures = 0;

   pipeline_ctrl #(.MUL_CYCLES(MC)) dut (
      .clk            (clk),
      .rst            (rst),
      .IF_ID_rn1      (IF_ID_rn1),
      .IF_ID_rn2      (IF_ID_rn2),
      .ID_EX_wn       (ID_EX_wn),
      .ID_EX_MemRead  (ID_EX_MemRead),
      .ID_EX_mul      (ID_EX_mul),
      .branch_taken   (branch_taken),
      .EX_MEM_mem_req (EX_MEM_mem_req),
      .mem_ready      (mem_ready),
      .halt           (halt),
      .pc_write       (pc_write),
      .IF_ID_write    (IF_ID_write),
      .IF_ID_flush    (IF_ID_flush),
      .ID_EX_bubble   (ID_EX_bubble),
      .ID_EX_write    (ID_EX_write),
      .EX_MEM_write   (EX_MEM_write),
      .MEM_WB_write   (MEM_WB_write),
      .mul_done       (mul_done),
      .state          (state),
      .stall_cnt      (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it and reports a miss on a single line.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle's worth of inputs just after the rising edge.
   task automatic applyStimulus(input logic r, input logic memRd, input logic [3:0] wn,
                                input logic [3:0] rn1, input logic [3:0] rn2,
                                input logic mul, input logic br, input logic req,
                                input logic rdy, input logic hlt);
      @(posedge clk);
      #1;
      rst            = r;
      ID_EX_MemRead  = memRd;
      ID_EX_wn       = wn;
      IF_ID_rn1      = rn1;
      IF_ID_rn2      = rn2;
      ID_EX_mul      = mul;
      branch_taken   = br;
      EX_MEM_mem_req = req;
      mem_ready      = rdy;
      halt           = hlt;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
   endtask

   // Behavioural model: the pipeline is halted, frozen on memory, or has
   // mMulLeft cycles of multiply occupancy still to go (0 = no multiply).
   bit mValid  = 0;
   bit mHalted = 0;
   bit mFrozen = 0;
   int mMulLeft = 0;
   int mStall   = 0;

   always @(negedge clk) begin
      bit loadUse, memBlock;
      bit ePc, eIfId, eIdEx, eExMem, eMemWb, eFlush, eBubble, eDone;
      bit nHalted, nFrozen;
      int nMul, eState;

      loadUse  = ID_EX_MemRead && (ID_EX_wn != 0) &&
                 ((ID_EX_wn == IF_ID_rn1) || (ID_EX_wn == IF_ID_rn2));
      memBlock = EX_MEM_mem_req && !mem_ready;
      ePc = 1; eIfId = 1; eIdEx = 1; eExMem = 1; eMemWb = 1;
      eFlush = 0; eBubble = 0; eDone = 0;
      nHalted = mHalted; nFrozen = mFrozen; nMul = mMulLeft;

      if (mHalted) begin
         eState = 3;
         ePc = 0; eIfId = 0; eIdEx = 0;
      end else begin
         eState = mFrozen ? 2 : ((mMulLeft > 0) ? 1 : 0);
         if ((mFrozen && !mem_ready) || (!mFrozen && memBlock)) begin
            ePc = 0; eIfId = 0; eIdEx = 0; eExMem = 0; eMemWb = 0;
            nFrozen = 1;
         end else begin
            nFrozen = 0;
            if (mMulLeft > 0) begin
               ePc = 0; eIfId = 0; eIdEx = 0;
               if (mMulLeft == 1) begin
                  eDone = 1; eBubble = 1;
               end else begin
                  eExMem = 0;
               end
               nMul = mMulLeft - 1;
            end else if (halt) begin
               nHalted = 1;
            end else if (branch_taken) begin
               eFlush = 1; eBubble = 1;
            end else if (ID_EX_mul) begin
               ePc = 0; eIfId = 0; eIdEx = 0; eExMem = 0;
               nMul = MC - 1;
            end else if (loadUse) begin
               ePc = 0; eIfId = 0; eBubble = 1;
            end
         end
      end

      if (mValid) begin
         checkOutput("model pc_write",     pc_write,     ePc);
         checkOutput("model IF_ID_write",  IF_ID_write,  eIfId);
         checkOutput("model ID_EX_write",  ID_EX_write,  eIdEx);
         checkOutput("model EX_MEM_write", EX_MEM_write, eExMem);
         checkOutput("model MEM_WB_write", MEM_WB_write, eMemWb);
         checkOutput("model IF_ID_flush",  IF_ID_flush,  eFlush);
         checkOutput("model ID_EX_bubble", ID_EX_bubble, eBubble);
         checkOutput("model mul_done",     mul_done,     eDone);
         checkOutput("model state",        state,        eState);
         checkOutput("model stall_cnt",    stall_cnt,    mStall);
      end

      if (rst) begin
         mValid = 1; mHalted = 0; mFrozen = 0; mMulLeft = 0; mStall = 0;
      end else begin
         if (!mHalted && !ePc && (mStall < 65535)) mStall = mStall + 1;
         mHalted = nHalted; mFrozen = nFrozen; mMulLeft = nMul;
      end
   end

   // Absolute time limit so a broken design can never hang the run.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected %0d cycles", 80000);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1; ID_EX_MemRead = 0; ID_EX_wn = 0; IF_ID_rn1 = 0; IF_ID_rn2 = 0;
      ID_EX_mul = 0; branch_taken = 0; EX_MEM_mem_req = 0; mem_ready = 1; halt = 0;

      // Reset, then the free-running state.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle();
      #2;
      checkOutput("reset state",     state,     3'd0);
      checkOutput("reset stall_cnt", stall_cnt, 16'd0);
      checkOutput("reset pc_write",  pc_write,  1'b1);
      checkOutput("reset MEM_WB",    MEM_WB_write, 1'b1);
      checkOutput("reset mul_done",  mul_done,  1'b0);

      // Load-use on rn2 stalls one cycle; destination r0 never stalls.
      applyStimulus(0, 1, 5, 1, 5, 0, 0, 0, 1, 0);
      #2;
      checkOutput("loaduse pc_write",    pc_write,     1'b0);
      checkOutput("loaduse IF_ID_write", IF_ID_write,  1'b0);
      checkOutput("loaduse bubble",      ID_EX_bubble, 1'b1);
      checkOutput("loaduse stall before", stall_cnt,   16'd0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      #2;
      checkOutput("loaduse stall after", stall_cnt,    16'd1);
      checkOutput("r0 pc_write",         pc_write,     1'b1);
      checkOutput("r0 bubble",           ID_EX_bubble, 1'b0);

      // Branch alongside load-use flushes rather than stalls.
      applyStimulus(0, 1, 7, 7, 2, 0, 1, 0, 1, 0);
      #2;
      checkOutput("branch flush",    IF_ID_flush,  1'b1);
      checkOutput("branch bubble",   ID_EX_bubble, 1'b1);
      checkOutput("branch pc_write", pc_write,     1'b1);
      idle();
      #2;
      checkOutput("branch stall_cnt", stall_cnt, 16'd1);

      // Plain multiply: three cycles held, done on the fourth.
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
      #2;
      checkOutput("mul c1 EX_MEM", EX_MEM_write, 1'b0);
      checkOutput("mul c1 state",  state,        3'd0);
      idle(); #2;
      checkOutput("mul c2 EX_MEM", EX_MEM_write, 1'b0);
      checkOutput("mul c2 state",  state,        3'd1);
      idle(); #2;
      checkOutput("mul c3 EX_MEM", EX_MEM_write, 1'b0);
      checkOutput("mul c3 done",   mul_done,     1'b0);
      idle(); #2;
      checkOutput("mul c4 EX_MEM", EX_MEM_write, 1'b1);
      checkOutput("mul c4 done",   mul_done,     1'b1);
      idle(); #2;
      checkOutput("mul after state", state,    3'd0);
      checkOutput("mul after done",  mul_done, 1'b0);
      checkOutput("mul stall_cnt",   stall_cnt, 16'd5);

      // Multiply frozen by memory for two cycles in its second cycle.
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      #2;
      checkOutput("mulmem t1 state", state, 3'd1);
      checkOutput("mulmem t1 MEM_WB", MEM_WB_write, 1'b0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      #2;
      checkOutput("mulmem t2 state", state, 3'd2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      #2;
      checkOutput("mulmem t3 state",  state,        3'd2);
      checkOutput("mulmem t3 done",   mul_done,     1'b0);
      checkOutput("mulmem t3 MEM_WB", MEM_WB_write, 1'b1);
      idle(); #2;
      checkOutput("mulmem t4 state", state,    3'd1);
      checkOutput("mulmem t4 done",  mul_done, 1'b0);
      idle(); #2;
      checkOutput("mulmem t5 done",  mul_done, 1'b1);
      idle(); #2;
      checkOutput("mulmem t6 state", state, 3'd0);

      // Halt drains, then only reset gets out.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      #2;
      checkOutput("halt entry state", state, 3'd0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, 0, 0, 0, 0, i[0], i[1], 0, 1, 1);
         #2;
         checkOutput("halted state",    state,        3'd3);
         checkOutput("halted pc_write", pc_write,     1'b0);
         checkOutput("halted EX_MEM",   EX_MEM_write, 1'b1);
      end
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(); #2;
      checkOutput("unhalt state",     state,     3'd0);
      checkOutput("unhalt stall_cnt", stall_cnt, 16'd0);

      // Long memory stall saturates the counter.
      for (int i = 0; i < 70000; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      #2;
      checkOutput("sat state",     state,     3'd2);
      checkOutput("sat stall_cnt", stall_cnt, 16'hFFFF);
      idle(); #2;
      checkOutput("sat resume pc_write", pc_write, 1'b1);
      idle(); #2;
      checkOutput("sat hold stall_cnt", stall_cnt, 16'hFFFF);
      checkOutput("sat resume state",   state,     3'd0);

      // Randomized traffic against the model.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] wn, rn1, rn2;
         wn  = 4'($urandom_range(0, 15));
         rn1 = ($urandom_range(0, 3) == 0) ? wn : 4'($urandom_range(0, 15));
         rn2 = ($urandom_range(0, 3) == 0) ? wn : 4'($urandom_range(0, 15));
         applyStimulus($urandom_range(0, 99) == 0,
                       $urandom_range(0, 9) < 3, wn, rn1, rn2,
                       $urandom_range(0, 99) < 8,
                       $urandom_range(0, 99) < 12,
                       $urandom_range(0, 9) < 3,
                       $urandom_range(0, 9) < 6,
                       $urandom_range(0, 99) == 0);
      end
      idle();
      idle();

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
